// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: two-stage pipelined priority encoder with valid/ready on
// both sides. N request bits are split into N/GROUP groups; stage 1 encodes
// each group locally, stage 2 picks the highest non-empty group and builds
// the full index {group, local index}. Bit N-1 has the highest priority.
//
// Optional feature macro: ENC_MULTIHOT_FLAG_EN
//   defined   -> per-group multi-hot flags, group-collision detection,
//                out_multi and the saturating err_cnt are built.
//   undefined -> out_multi and err_cnt are tied to 0; encoding, latency and
//                handshake are unchanged.

// Local encoder for one group of request bits.
module prio_enc_grp #(
    parameter int GROUP = 8,
    parameter int LW    = $clog2(GROUP)
) (
    input  logic [GROUP-1:0] bits,
    output logic             any,
    output logic [LW-1:0]    lidx
`ifdef ENC_MULTIHOT_FLAG_EN
    ,
    output logic             many
`endif
);

    // Highest set bit wins: scan upward so the last hit is the top one.
    always_comb begin
        any  = 1'b0;
        lidx = '0;
        for (int i = 0; i < GROUP; i++) begin
            if (bits[i]) begin
                any  = 1'b1;
                lidx = i[LW-1:0];
            end
        end
    end

`ifdef ENC_MULTIHOT_FLAG_EN
    // A second set bit seen after the first one marks the group multi-hot.
    always_comb begin
        logic seen;
        seen = 1'b0;
        many = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            if (bits[i]) begin
                if (seen) many = 1'b1;
                seen = 1'b1;
            end
        end
    end
`endif

endmodule

module prio_enc_pipe #(
    parameter int N     = 16,
    parameter int GROUP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_zero,
    output logic                 out_multi,
    output logic [7:0]           err_cnt
);

    localparam int G  = N / GROUP;
    localparam int LW = $clog2(GROUP);
    localparam int GW = $clog2(G);
    localparam int IW = $clog2(N);

    // ------------------------------------------------------------------
    // Handshake: each stage moves when its successor can take the data.
    // in_ready is the only combinational path (from out_ready).
    // ------------------------------------------------------------------
    logic v1, v2;
    logic adv1, adv2;

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;
    assign out_valid = v2;

    // ------------------------------------------------------------------
    // Stage 1: per-group local encoders (combinational) and their registers
    // ------------------------------------------------------------------
    logic [G-1:0]         any_c;
    logic [G-1:0][LW-1:0] lidx_c;
    logic [G-1:0]         any1;
    logic [G-1:0][LW-1:0] lidx1;
`ifdef ENC_MULTIHOT_FLAG_EN
    logic [G-1:0]         many_c;
    logic [G-1:0]         many1;
`endif

    for (genvar gi = 0; gi < G; gi++) begin : g_grp
        prio_enc_grp #(
            .GROUP (GROUP),
            .LW    (LW)
        ) u_grp (
            .bits (in_req[gi*GROUP +: GROUP]),
            .any  (any_c[gi]),
            .lidx (lidx_c[gi])
`ifdef ENC_MULTIHOT_FLAG_EN
            ,
            .many (many_c[gi])
`endif
        );
    end

    // Stage-1 register: load a new word whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            any1  <= '0;
            lidx1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                any1  <= any_c;
                lidx1 <= lidx_c;
            end
        end
    end

`ifdef ENC_MULTIHOT_FLAG_EN
    // Stage-1 multi-hot flags follow the same load condition as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            many1 <= '0;
        end else if (adv1 && in_valid) begin
            many1 <= many_c;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 2: pick the highest non-empty group and form the full index
    // ------------------------------------------------------------------
    logic [GW-1:0] sel_g;
    logic [IW-1:0] idx_c;
    logic          zero_c;

    // Highest group with any set bit; an all-empty word falls out as index 0.
    always_comb begin
        sel_g = '0;
        for (int g = 0; g < G; g++) begin
            if (any1[g]) sel_g = g[GW-1:0];
        end
        zero_c = ~|any1;
        idx_c  = {sel_g, lidx1[sel_g]};
    end

`ifdef ENC_MULTIHOT_FLAG_EN
    logic multi_c;

    // Multi-hot if any group has several bits or several groups are hit.
    always_comb begin
        logic seen;
        logic coll;
        seen = 1'b0;
        coll = 1'b0;
        for (int g = 0; g < G; g++) begin
            if (any1[g]) begin
                if (seen) coll = 1'b1;
                seen = 1'b1;
            end
        end
        multi_c = (|many1) || coll;
    end
`endif

    // Stage-2 / output register: hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            out_idx  <= '0;
            out_zero <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_idx  <= idx_c;
                out_zero <= zero_c;
            end
        end
    end

`ifdef ENC_MULTIHOT_FLAG_EN
    // Multi-hot flag travels with the result in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_multi <= 1'b0;
        end else if (adv2 && v1) begin
            out_multi <= multi_c;
        end
    end

    // Count delivered multi-hot results, sticking at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (v2 && out_ready && out_multi && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign out_multi = 1'b0;
    assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Directed, table-driven bench for prio_enc_pipe (N=16, GROUP=8), plus
// hand-written sequences for backpressure, saturation and mid-stream reset.
module tb_prio_enc_pipe;

`ifdef ENC_MULTIHOT_FLAG_EN
    localparam bit MH = 1'b1;
`else
    localparam bit MH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_req;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_zero;
    logic        out_multi;
    logic [7:0]  err_cnt;

    prio_enc_pipe #(.N(16), .GROUP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic [3:0]  idx;
        logic        zero;
        logic        multi;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] r, input logic [3:0] i,
                                input logic z, input logic m);
        vec_t v;
        v.req = r; v.idx = i; v.zero = z; v.multi = m;
        return v;
    endfunction

    // Present one word into an empty pipe at a negedge and wait for its result.
    task automatic send_one(input logic [15:0] req, output int lat);
        in_valid  = 1'b1;
        in_req    = req;
        out_ready = 1'b1;
        #1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_req   = 16'hDEAD;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int acc;
        int cyc;
        int vcnt;
        logic [15:0] words[5];
        logic [3:0]  exp_q[5];
        logic [3:0]  got[$];

        // Priority cases first so err_cnt=2 is checked right after them.
        tbl.push_back(mk(16'h0081, 4'd7,  1'b0, 1'b1));
        tbl.push_back(mk(16'h8100, 4'd15, 1'b0, 1'b1));
        tbl.push_back(mk(16'h0100, 4'd8,  1'b0, 1'b0));
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(16'(1 << k), k[3:0], 1'b0, 1'b0));
        tbl.push_back(mk(16'h0000, 4'd0,  1'b1, 1'b0));
        tbl.push_back(mk(16'hFFFF, 4'd15, 1'b0, 1'b1));
        tbl.push_back(mk(16'h0003, 4'd1,  1'b0, 1'b1));
        tbl.push_back(mk(16'h0300, 4'd9,  1'b0, 1'b1));
        tbl.push_back(mk(16'h0180, 4'd8,  1'b0, 1'b1));
        tbl.push_back(mk(16'h0040, 4'd6,  1'b0, 1'b0));

        rst = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx",   int'(out_idx),   0);
        chk("rst_out_zero",  int'(out_zero),  0);
        chk("rst_out_multi", int'(out_multi), 0);
        chk("rst_err_cnt",   int'(err_cnt),   0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Table: one word at a time through an empty pipe.
        for (int i = 0; i < tbl.size(); i++) begin
            send_one(tbl[i].req, lat);
            chk($sformatf("lat[%0d]", i),   lat, 2);
            chk($sformatf("valid[%0d]", i), int'(out_valid), 1);
            chk($sformatf("idx[%0d]", i),   int'(out_idx),   int'(tbl[i].idx));
            chk($sformatf("zero[%0d]", i),  int'(out_zero),  int'(tbl[i].zero));
            chk($sformatf("multi[%0d]", i), int'(out_multi), MH ? int'(tbl[i].multi) : 0);
            @(negedge clk);
            if (MH && tbl[i].multi && exp_err < 255) exp_err++;
            chk($sformatf("err_cnt[%0d]", i), int'(err_cnt), exp_err);
            if (i == 2) chk("err_cnt_after_prio", int'(err_cnt), MH ? 2 : 0);
        end

        // Backpressure: 5 words streamed against a stalled consumer.
        words = '{16'h0001, 16'h0020, 16'h0400, 16'h8000, 16'h0008};
        exp_q = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd3};
        acc = 0; cyc = 0;
        while (got.size() < 5 && cyc < 40) begin
            in_valid  = (acc < 5);
            in_req    = (acc < 5) ? words[acc] : 16'h0;
            out_ready = (cyc >= 6);
            #1;
            if (cyc == 3) begin
                chk("bp_in_ready_full", int'(in_ready), 0);
                chk("bp_accepts",       acc, 2);
                chk("bp_hold_valid",    int'(out_valid), 1);
                chk("bp_hold_idx",      int'(out_idx), 0);
            end
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) got.push_back(out_idx);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("bp_order[%0d]", i), int'(got[i]), int'(exp_q[i]));
        repeat (3) @(negedge clk);
        chk("bp_drained", int'(out_valid), 0);

        // Saturation: 300 multi-hot words at full throughput.
        out_ready = 1'b1;
        in_req    = 16'hFFFF;
        in_valid  = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        if (MH) exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
        chk("sat_err_cnt", int'(err_cnt), exp_err);

        // Reset with both stages full: nothing stale may emerge afterwards.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_req    = 16'h0081;
        repeat (2) @(negedge clk);
        chk("rs_full_in_ready", int'(in_ready), 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_out_valid", int'(out_valid), 0);
        chk("rs_err_cnt",   int'(err_cnt),   0);
        chk("rs_in_ready",  int'(in_ready),  1);
        rst = 1'b0;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("rs_no_stale", vcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
